// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single-word SDRAM controller: port 0 has strict priority,
// ports 1/2 alternate round-robin, and a free-running timer schedules refresh between accesses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no command outstanding; pick refresh, port 0, or port 1/2 RR
// ACCESS  | mem_req held for the granted port until mem_ack or timeout
// REFRESH | mem_ref held until mem_ack or timeout
module sdram_port_arbiter #(
    parameter int AW           = 24,
    parameter int DW           = 16,
    parameter int REF_INTERVAL = 1664,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [2:0]        p_req,
    input  logic [3*AW-1:0]   p_addr,
    input  logic [2:0]        p_we,
    input  logic [3*DW-1:0]   p_din,
    input  logic [5:0]        p_be,
    output logic [2:0]        p_ack,
    output logic [DW-1:0]     p_dout,
    output logic              mem_req,
    output logic              mem_ref,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_din,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_dout,
    output logic              err,
    output logic              ref_miss
);

    localparam int RCW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RCW-1:0] REF_LAST = RCW'(REF_INTERVAL - 1);
    // Watchdog counts down from TIMEOUT-1 so the command is held for exactly TIMEOUT cycles.
    localparam logic [WDW-1:0] WD_LOAD  = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        REFRESH = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic           rr_q, rr_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [RCW-1:0] ref_cnt;
    logic           ref_wrap;
    logic           ref_pend_q, ref_pend_d;
    logic           ref_done;
    logic           wd_expired;
    logic [2:0]     eff_req;
    logic           take;
    logic [1:0]     sel;

    logic           req_d, ref_d, we_d, err_d, miss_d;
    logic [AW-1:0]  addr_d;
    logic [DW-1:0]  din_d, dout_d;
    logic [1:0]     be_d;
    logic [2:0]     ack_d;

    logic [AW-1:0]  addr_v [3];
    logic [DW-1:0]  din_v  [3];
    logic [1:0]     be_v   [3];

    for (genvar i = 0; i < 3; i++) begin : g_port
        assign addr_v[i] = p_addr[i*AW +: AW];
        assign din_v[i]  = p_din[i*DW +: DW];
        assign be_v[i]   = p_be[i*2 +: 2];
    end

    assign ref_wrap   = (ref_cnt == REF_LAST);
    assign wd_expired = (TIMEOUT != 0) && (wd_q == '0);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ref_cnt <= '0;
        end else if (ref_wrap) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + RCW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        wd_d     = wd_q;
        req_d    = mem_req;
        ref_d    = mem_ref;
        addr_d   = mem_addr;
        we_d     = mem_we;
        din_d    = mem_din;
        be_d     = mem_be;
        ack_d    = '0;
        dout_d   = '0;
        err_d    = 1'b0;
        ref_done = 1'b0;
        take     = 1'b0;
        sel      = 2'd0;
        // A port being acked this cycle must re-request before it can win again.
        eff_req  = p_req & ~p_ack;

        case (state_q)
            IDLE: begin
                if (ref_pend_q) begin
                    state_d = REFRESH;
                    ref_d   = 1'b1;
                    wd_d    = WD_LOAD;
                end else if (eff_req[0]) begin
                    take = 1'b1;
                    sel  = 2'd0;
                end else if (eff_req[1] || eff_req[2]) begin
                    take = 1'b1;
                    if (!rr_q) begin
                        sel = eff_req[1] ? 2'd1 : 2'd2;
                    end else begin
                        sel = eff_req[2] ? 2'd2 : 2'd1;
                    end
                    rr_d = (sel == 2'd1);
                end

                if (take) begin
                    state_d = ACCESS;
                    grant_d = sel;
                    req_d   = 1'b1;
                    wd_d    = WD_LOAD;
                    addr_d  = addr_v[sel];
                    we_d    = p_we[sel];
                    din_d   = din_v[sel];
                    be_d    = be_v[sel];
                end
            end

            ACCESS: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ack_d   = 3'b001 << grant_q;
                    dout_d  = mem_dout;
                end else if (wd_expired) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ack_d   = 3'b001 << grant_q;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q - WDW'(1);
                end
            end

            REFRESH: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    ref_d    = 1'b0;
                    ref_done = 1'b1;
                end else if (wd_expired) begin
                    state_d  = IDLE;
                    ref_d    = 1'b0;
                    ref_done = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    wd_d = wd_q - WDW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                ref_d   = 1'b0;
            end
        endcase

        // A wrap coinciding with refresh completion re-arms pending rather than clearing it.
        ref_pend_d = ref_pend_q;
        if (ref_done) begin
            ref_pend_d = 1'b0;
        end
        if (ref_wrap) begin
            ref_pend_d = 1'b1;
        end
        miss_d = ref_wrap && ref_pend_q && !ref_done;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 2'd0;
            rr_q       <= 1'b0;
            wd_q       <= '0;
            ref_pend_q <= 1'b0;
            mem_req    <= 1'b0;
            mem_ref    <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_din    <= '0;
            mem_be     <= 2'b00;
            p_ack      <= 3'b000;
            p_dout     <= '0;
            err        <= 1'b0;
            ref_miss   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            wd_q       <= wd_d;
            ref_pend_q <= ref_pend_d;
            mem_req    <= req_d;
            mem_ref    <= ref_d;
            mem_addr   <= addr_d;
            mem_we     <= we_d;
            mem_din    <= din_d;
            mem_be     <= be_d;
            p_ack      <= ack_d;
            p_dout     <= dout_d;
            err        <= err_d;
            ref_miss   <= miss_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: instance a uses a short watchdog, instance b a short
// refresh interval; each is held in reset while the other is exercised.
module tb_sdram_port_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic            reset_a, reset_b;
    logic [2:0]      p_req;
    logic [3*AW-1:0] p_addr;
    logic [2:0]      p_we;
    logic [3*DW-1:0] p_din;
    logic [5:0]      p_be;
    logic            mem_ack_a, mem_ack_b;
    logic [DW-1:0]   mem_dout_a, mem_dout_b;

    logic [2:0]      p_ack_a, p_ack_b;
    logic [DW-1:0]   p_dout_a, p_dout_b;
    logic            mem_req_a, mem_req_b, mem_ref_a, mem_ref_b;
    logic [AW-1:0]   mem_addr_a, mem_addr_b;
    logic            mem_we_a, mem_we_b;
    logic [DW-1:0]   mem_din_a, mem_din_b;
    logic [1:0]      mem_be_a, mem_be_b;
    logic            err_a, err_b, ref_miss_a, ref_miss_b;

    sdram_port_arbiter #(.AW(AW), .DW(DW), .REF_INTERVAL(1664), .TIMEOUT(8)) dut_a (
        .clk_sys(clk_sys), .reset(reset_a),
        .p_req(p_req), .p_addr(p_addr), .p_we(p_we), .p_din(p_din), .p_be(p_be),
        .p_ack(p_ack_a), .p_dout(p_dout_a),
        .mem_req(mem_req_a), .mem_ref(mem_ref_a), .mem_addr(mem_addr_a), .mem_we(mem_we_a),
        .mem_din(mem_din_a), .mem_be(mem_be_a), .mem_ack(mem_ack_a), .mem_dout(mem_dout_a),
        .err(err_a), .ref_miss(ref_miss_a)
    );

    sdram_port_arbiter #(.AW(AW), .DW(DW), .REF_INTERVAL(16), .TIMEOUT(255)) dut_b (
        .clk_sys(clk_sys), .reset(reset_b),
        .p_req(p_req), .p_addr(p_addr), .p_we(p_we), .p_din(p_din), .p_be(p_be),
        .p_ack(p_ack_b), .p_dout(p_dout_b),
        .mem_req(mem_req_b), .mem_ref(mem_ref_b), .mem_addr(mem_addr_b), .mem_we(mem_we_b),
        .mem_din(mem_din_b), .mem_be(mem_be_b), .mem_ack(mem_ack_b), .mem_dout(mem_dout_b),
        .err(err_b), .ref_miss(ref_miss_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int n, input logic [AW-1:0] a, input logic we,
                            input logic [DW-1:0] d, input logic [1:0] be);
        p_addr[n*AW +: AW] = a;
        p_we[n]            = we;
        p_din[n*DW +: DW]  = d;
        p_be[n*2 +: 2]     = be;
    endtask

    task automatic restart_a();
        reset_a   = 1'b1;
        p_req     = 3'b000;
        mem_ack_a = 1'b0;
        tick();
        tick();
        reset_a   = 1'b0;
    endtask

    int          exp_port;
    logic [2:0]  exp_ack;
    logic        prev_req, prev_ref;
    int          req_age, ref_age, nref, rise1, rise2, fall2, miss_cnt, miss_at, overlap;
    logic        req57;

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        p_req = '0; p_addr = '0; p_we = '0; p_din = '0; p_be = '0;
        mem_ack_a = 1'b0; mem_ack_b = 1'b0; mem_dout_a = '0; mem_dout_b = '0;
        tick();
        tick();

        // reset values
        chk("rst_mem_req",  64'(mem_req_a),  0);
        chk("rst_mem_ref",  64'(mem_ref_a),  0);
        chk("rst_p_ack",    64'(p_ack_a),    0);
        chk("rst_p_dout",   64'(p_dout_a),   0);
        chk("rst_mem_addr", 64'(mem_addr_a), 0);
        chk("rst_err",      64'(err_a),      0);
        chk("rst_ref_miss", 64'(ref_miss_a), 0);
        reset_a = 1'b0;

        // single read on port 1, controller answers 5 cycles after mem_req
        set_port(1, 24'h000123, 1'b0, 16'h0000, 2'b11);
        p_req = 3'b010;
        tick();
        chk("t1_latency", 64'(mem_req_a),  1);
        chk("t1_addr",    64'(mem_addr_a), 64'h123);
        chk("t1_we",      64'(mem_we_a),   0);
        chk("t1_no_ref",  64'(mem_ref_a),  0);
        repeat (4) tick();
        chk("t1_hold", 64'(mem_req_a), 1);
        tick();
        mem_ack_a = 1'b1; mem_dout_a = 16'hBEEF;
        tick();
        mem_ack_a = 1'b0; mem_dout_a = 16'h0000; p_req = 3'b000;
        chk("t1_p_ack",   64'(p_ack_a),   64'b010);
        chk("t1_p_dout",  64'(p_dout_a),  64'hBEEF);
        chk("t1_req_low", 64'(mem_req_a), 0);
        tick();
        chk("t1_ack_once", 64'(p_ack_a),  0);
        chk("t1_dout_clr", 64'(p_dout_a), 0);

        // ports 1 and 2 held: grants alternate 1,2,1,2 with one idle cycle between
        restart_a();
        set_port(1, 24'h000111, 1'b0, 16'h0000, 2'b11);
        set_port(2, 24'h000222, 1'b0, 16'h0000, 2'b11);
        p_req = 3'b110;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_port = (i % 2 == 0) ? 1 : 2;
            exp_ack  = 3'b000;
            exp_ack[exp_port] = 1'b1;
            chk($sformatf("t2_req%0d", i), 64'(mem_req_a), 1);
            chk($sformatf("t2_addr%0d", i), 64'(mem_addr_a),
                (exp_port == 1) ? 64'h111 : 64'h222);
            mem_ack_a  = 1'b1;
            mem_dout_a = 16'h1000 + 16'(i);
            tick();
            mem_ack_a = 1'b0;
            if (i == 3) p_req = 3'b000;
            chk($sformatf("t2_ack%0d", i),  64'(p_ack_a),   64'(exp_ack));
            chk($sformatf("t2_dout%0d", i), 64'(p_dout_a),  64'h1000 + 64'(i));
            chk($sformatf("t2_gap%0d", i),  64'(mem_req_a), 0);
            tick();
        end
        chk("t2_quiet", 64'(mem_req_a), 0);

        // all three request together: port 0 first, then port 1
        restart_a();
        set_port(0, 24'h0000A0, 1'b1, 16'h5555, 2'b01);
        set_port(1, 24'h000111, 1'b0, 16'h0000, 2'b11);
        set_port(2, 24'h000222, 1'b0, 16'h0000, 2'b11);
        p_req = 3'b111;
        tick();
        chk("t3_p0_addr", 64'(mem_addr_a), 64'hA0);
        chk("t3_p0_we",   64'(mem_we_a),   1);
        chk("t3_p0_din",  64'(mem_din_a),  64'h5555);
        chk("t3_p0_be",   64'(mem_be_a),   64'b01);
        mem_ack_a = 1'b1;
        tick();
        mem_ack_a = 1'b0;
        chk("t3_p0_ack", 64'(p_ack_a), 64'b001);
        p_req = 3'b110;
        tick();
        chk("t3_second_req",  64'(mem_req_a),  1);
        chk("t3_second_addr", 64'(mem_addr_a), 64'h111);
        mem_ack_a = 1'b1;
        tick();
        mem_ack_a = 1'b0;
        chk("t3_p1_ack", 64'(p_ack_a), 64'b010);
        p_req = 3'b000;
        tick();

        // port 2 write never acknowledged: abort after 8 cycles
        restart_a();
        set_port(2, 24'h003456, 1'b1, 16'hA5A5, 2'b10);
        p_req = 3'b100;
        mem_dout_a = 16'hFFFF;
        tick();
        chk("t5_req",  64'(mem_req_a),  1);
        chk("t5_addr", 64'(mem_addr_a), 64'h3456);
        chk("t5_we",   64'(mem_we_a),   1);
        chk("t5_din",  64'(mem_din_a),  64'hA5A5);
        chk("t5_be",   64'(mem_be_a),   64'b10);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("t5_hold%0d", k), 64'(mem_req_a), 1);
        end
        chk("t5_no_err_yet", 64'(err_a), 0);
        tick();
        chk("t5_req_drop", 64'(mem_req_a), 0);
        chk("t5_err",      64'(err_a),     1);
        chk("t5_p_ack",    64'(p_ack_a),   64'b100);
        chk("t5_p_dout",   64'(p_dout_a),  0);
        p_req = 3'b000;
        tick();
        chk("t5_err_pulse", 64'(err_a),   0);
        chk("t5_ack_pulse", 64'(p_ack_a), 0);
        set_port(2, 24'h000777, 1'b0, 16'h0000, 2'b11);
        p_req = 3'b100;
        tick();
        chk("t5_next_req",  64'(mem_req_a),  1);
        chk("t5_next_addr", 64'(mem_addr_a), 64'h777);
        mem_ack_a = 1'b1; mem_dout_a = 16'h1234;
        tick();
        mem_ack_a = 1'b0; p_req = 3'b000;
        chk("t5_next_ack",  64'(p_ack_a),  64'b100);
        chk("t5_next_dout", 64'(p_dout_a), 64'h1234);
        chk("t5_next_err",  64'(err_a),    0);
        tick();

        // reset while in ACCESS
        restart_a();
        set_port(1, 24'h000111, 1'b0, 16'h0000, 2'b11);
        set_port(2, 24'h000222, 1'b0, 16'h0000, 2'b11);
        p_req = 3'b010;
        tick();
        chk("t6_in_access", 64'(mem_req_a), 1);
        #2;
        reset_a = 1'b1;
        p_req   = 3'b000;
        #1;
        chk("t6_req_async",  64'(mem_req_a),  0);
        chk("t6_addr_async", 64'(mem_addr_a), 0);
        chk("t6_ack_async",  64'(p_ack_a),    0);
        chk("t6_err_async",  64'(err_a),      0);
        tick();
        tick();
        reset_a   = 1'b0;
        mem_ack_a = 1'b1;
        tick();
        mem_ack_a = 1'b0;
        chk("t6_late_ack", 64'(p_ack_a),   0);
        chk("t6_late_err", 64'(err_a),     0);
        chk("t6_idle",     64'(mem_req_a), 0);
        p_req = 3'b110;
        tick();
        chk("t6_first_req",  64'(mem_req_a),  1);
        chk("t6_first_port", 64'(mem_addr_a), 64'h111);
        mem_ack_a = 1'b1;
        tick();
        mem_ack_a = 1'b0;
        p_req = 3'b000;
        tick();

        // refresh scheduling on instance b with continuous port-1 traffic
        reset_a = 1'b1;
        set_port(1, 24'h0000B0, 1'b0, 16'h0000, 2'b11);
        p_req    = 3'b010;
        reset_b  = 1'b0;
        prev_req = 1'b0; prev_ref = 1'b0;
        req_age  = 0; ref_age = 0; nref = 0;
        rise1 = -1; rise2 = -1; fall2 = -1;
        miss_cnt = 0; miss_at = -1; overlap = 0; req57 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (mem_req_b && mem_ref_b) overlap++;
            if (ref_miss_b) begin
                miss_cnt++;
                miss_at = c;
            end
            if (mem_ref_b && !prev_ref) begin
                nref++;
                if (nref == 1) rise1 = c;
                else if (nref == 2) rise2 = c;
                ref_age = 0;
            end else if (mem_ref_b) begin
                ref_age++;
            end
            if (!mem_ref_b && prev_ref && nref == 2) fall2 = c;
            if (mem_req_b && !prev_req) req_age = 0;
            else if (mem_req_b) req_age++;
            if (c == 57) req57 = mem_req_b;
            mem_ack_b = (mem_req_b && req_age == 1) ||
                        (mem_ref_b && ref_age == ((nref == 1) ? 1 : 20));
            prev_req = mem_req_b;
            prev_ref = mem_ref_b;
            tick();
        end
        mem_ack_b = 1'b0;
        p_req     = 3'b000;
        chk("t4_ref1_rise",   64'(rise1),    17);
        chk("t4_ref2_rise",   64'(rise2),    35);
        chk("t4_ref2_fall",   64'(fall2),    56);
        chk("t4_ref_count",   64'(nref),     2);
        chk("t4_miss_count",  64'(miss_cnt), 1);
        chk("t4_miss_cycle",  64'(miss_at),  48);
        chk("t4_no_overlap",  64'(overlap),  0);
        chk("t4_resume_req",  64'(req57),    1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
